// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite RAM slave among N simple requesters.
// One transaction in flight; each request becomes AW+W/B or AR/R on the master side.
module ram_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    we,
    input  logic [N*AW-1:0] addr,
    input  logic [N*DW-1:0] wdata,
    input  logic [N*DW/8-1:0] wstrb,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [AW-1:0]   m_awaddr,
    output logic            m_wvalid,
    input  logic            m_wready,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic            m_bvalid,
    output logic            m_bready,
    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [AW-1:0]   m_araddr,
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [DW-1:0]   m_rdata
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DW / 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RRESP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic          win_found;
    logic [IW-1:0] win_id;
    logic          grant_ok;

    // Search starts just past the last winner so every requester gets its turn.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

    // The idle cycle that carries rsp_valid is not granted, so the next grant
    // always follows the response by one cycle; reset forces gnt low at once.
    assign grant_ok = aresetn && (state_q == S_IDLE) && (rsp_valid_q == '0) && win_found;

    always_comb begin
        gnt = '0;
        if (grant_ok) gnt[win_id] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    id_d      = win_id;
                    last_d    = win_id;
                    addr_d    = addr[int'(win_id)*AW +: AW];
                    wdata_d   = wdata[int'(win_id)*DW +: DW];
                    wstrb_d   = we[win_id] ? wstrb[int'(win_id)*SW +: SW] : '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = we[win_id] ? S_WADDR : S_RADDR;
                end
            end
            S_WADDR: begin
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if (aw_done_d && w_done_d) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (m_bvalid) begin
                    rsp_valid_d[id_q] = 1'b1;
                    state_d           = S_IDLE;
                end
            end
            S_RADDR: begin
                if (m_arready) begin
                    if (m_rvalid) begin
                        rsp_rdata_d       = m_rdata;
                        rsp_valid_d[id_q] = 1'b1;
                        state_d           = S_IDLE;
                    end else begin
                        state_d = S_RRESP;
                    end
                end
            end
            S_RRESP: begin
                if (m_rvalid) begin
                    rsp_rdata_d       = m_rdata;
                    rsp_valid_d[id_q] = 1'b1;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(N - 1);
            id_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Read ready rides along with arvalid: the RAM only accepts an address while rready is high.
    assign m_awvalid = (state_q == S_WADDR) && !aw_done_q;
    assign m_wvalid  = (state_q == S_WADDR) && !w_done_q;
    assign m_bready  = (state_q == S_WRESP);
    assign m_arvalid = (state_q == S_RADDR);
    assign m_rready  = (state_q == S_RADDR) || (state_q == S_RRESP);
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
